// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    // Counter widths cover the legal parameter ranges (STARVE_MAX <= 15, TIMEOUT <= 255).
    localparam int STARVE_W = 4;
    localparam int WDOG_W   = 8;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                    input logic [STARVE_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the WAIT state: cleared while idle, counts each waiting cycle,
// flags expiry on the last cycle an ack may still arrive.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters: data-first
// arbitration with fetch starvation guard, latched memory request, watchdog abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_we,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                i_gnt_q, i_gnt_d, i_done_q, i_done_d, i_err_q, i_err_d;
    logic                d_gnt_q, d_gnt_d, d_done_q, d_done_d, d_err_q, d_err_d;
    logic [DW-1:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                m_req_q, m_req_d;
    logic [AW-1:0]       m_addr_q, m_addr_d;
    logic [3:0]          m_we_q, m_we_d;
    logic [DW-1:0]       m_wdata_q, m_wdata_d;
    logic                busy_q, busy_d;

    logic                wd_expire;
    logic                pick_data;
    logic                rsp_err;
    logic [DW-1:0]       rsp_rdata;

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ARB_IDLE),
        .en     (state_q == ARB_WAIT),
        .expire (wd_expire)
    );

    // Data wins unless fetch has been passed over STARVE_MAX times in a row.
    assign pick_data = d_req && !(i_req && (starve_q >= STARVE_LIM));
    // An ack in the expiry cycle still counts as a successful completion.
    assign rsp_err   = !m_ack;
    assign rsp_rdata = (m_ack && (m_we_q == 4'h0)) ? m_rdata : '0;

    always_comb begin
        // NOTE: every next-state value starts as a hold (or pulse-clear) default so no path through the case leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        i_gnt_d   = 1'b0;
        i_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        d_gnt_d   = 1'b0;
        d_done_d  = 1'b0;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        m_req_d   = m_req_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ARB_WAIT;
                    m_req_d = 1'b1;
                    if (pick_data) begin
                        owner_d   = OWN_D;
                        d_gnt_d   = 1'b1;
                        m_addr_d  = d_addr;
                        m_we_d    = d_we;
                        m_wdata_d = d_wdata;
                        if (i_req) begin
                            starve_d = sat_inc(starve_q, STARVE_LIM);
                        end
                    end else begin
                        owner_d   = OWN_I;
                        i_gnt_d   = 1'b1;
                        m_addr_d  = i_addr;
                        m_we_d    = 4'h0;
                        m_wdata_d = '0;
                        starve_d  = '0;
                    end
                end
            end
            ARB_WAIT: begin
                if (m_ack || wd_expire) begin
                    state_d = ARB_RESP;
                    m_req_d = 1'b0;
                    m_we_d  = 4'h0;
                    if (owner_q == OWN_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = rsp_rdata;
                        d_err_d   = rsp_err;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = rsp_rdata;
                        i_err_d   = rsp_err;
                    end
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the latched datapath registers are reset too, because every output must read 0 straight after reset.
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            starve_q  <= '0;
            i_gnt_q   <= 1'b0;
            i_done_q  <= 1'b0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_we_q    <= 4'h0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            i_gnt_q   <= i_gnt_d;
            i_done_q  <= i_done_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            d_gnt_q   <= d_gnt_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
        end
    end

    assign i_gnt   = i_gnt_q;
    assign i_done  = i_done_q;
    assign i_rdata = i_rdata_q;
    assign i_err   = i_err_q;
    assign d_gnt   = d_gnt_q;
    assign d_done  = d_done_q;
    assign d_rdata = d_rdata_q;
    assign d_err   = d_err_q;
    assign m_req   = m_req_q;
    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;
    localparam int NEVER      = 1000;

    logic          clk, rst;
    logic          i_req, i_gnt, i_done, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_gnt, d_done, d_err;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_we;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_ack, busy;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_we;
    logic [DW-1:0] m_wdata, m_rdata;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic          exp_i_gnt, exp_i_done, exp_i_err, exp_d_gnt, exp_d_done, exp_d_err;
    logic          exp_m_req, exp_busy;
    logic [DW-1:0] exp_i_rdata, exp_d_rdata, exp_m_wdata;
    logic [AW-1:0] exp_m_addr;
    logic [3:0]    exp_m_we;
    bit            acc_on, resp_on, acc_is_data, acc_is_write, take_data;
    int            age, fetch_passed, n_access;

    always @(posedge clk) begin : model
        if (!rst) begin
            {exp_i_gnt, exp_i_done, exp_i_err, exp_d_gnt, exp_d_done, exp_d_err} = '0;
            {exp_m_req, exp_busy} = '0;
            exp_i_rdata = '0; exp_d_rdata = '0; exp_m_wdata = '0;
            exp_m_addr = '0; exp_m_we = '0;
            acc_on = 1'b0; resp_on = 1'b0; fetch_passed = 0;
        end else begin
            {exp_i_gnt, exp_d_gnt, exp_i_done, exp_d_done} = '0;
            if (resp_on) begin
                resp_on = 1'b0;
            end else if (acc_on) begin
                age++;
                if (m_ack || age == TIMEOUT) begin
                    acc_on = 1'b0; resp_on = 1'b1; n_access++;
                    exp_m_req = 1'b0; exp_m_we = 4'h0;
                    if (acc_is_data) begin
                        exp_d_done = 1'b1; exp_d_err = !m_ack;
                        exp_d_rdata = (m_ack && !acc_is_write) ? m_rdata : '0;
                    end else begin
                        exp_i_done = 1'b1; exp_i_err = !m_ack;
                        exp_i_rdata = m_ack ? m_rdata : '0;
                    end
                end
            end else if (i_req || d_req) begin
                take_data = d_req && !(i_req && fetch_passed >= STARVE_MAX);
                acc_on = 1'b1; age = 0; exp_m_req = 1'b1; acc_is_data = take_data;
                if (take_data) begin
                    exp_d_gnt = 1'b1; exp_m_addr = d_addr; exp_m_we = d_we;
                    exp_m_wdata = d_wdata; acc_is_write = (d_we != 4'h0);
                    if (i_req) fetch_passed++;
                end else begin
                    exp_i_gnt = 1'b1; exp_m_addr = i_addr; exp_m_we = 4'h0;
                    exp_m_wdata = '0; acc_is_write = 1'b0; fetch_passed = 0;
                end
            end
            exp_busy = acc_on || resp_on;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("cmp_i_gnt", i_gnt, exp_i_gnt);
            check("cmp_i_done", i_done, exp_i_done);
            check("cmp_i_rdata", i_rdata, exp_i_rdata);
            check("cmp_i_err", i_err, exp_i_err);
            check("cmp_d_gnt", d_gnt, exp_d_gnt);
            check("cmp_d_done", d_done, exp_d_done);
            check("cmp_d_rdata", d_rdata, exp_d_rdata);
            check("cmp_d_err", d_err, exp_d_err);
            check("cmp_m_req", m_req, exp_m_req);
            check("cmp_m_addr", m_addr, exp_m_addr);
            check("cmp_m_we", m_we, exp_m_we);
            check("cmp_m_wdata", m_wdata, exp_m_wdata);
            check("cmp_busy", busy, exp_busy);
        end
    end

    // Grant log: owner 1 = data, 0 = fetch, with the cycle it was seen.
    int glog_own[$];
    int glog_cyc[$];
    always @(negedge clk) begin
        if (i_gnt) begin glog_own.push_back(0); glog_cyc.push_back(cyc); end
        if (d_gnt) begin glog_own.push_back(1); glog_cyc.push_back(cyc); end
    end

    // ---------------- memory responder ----------------
    int            fixed_lat = 0;
    logic [DW-1:0] ack_data = '0;
    bit            rand_mode = 1'b0;
    bit            spur_ack = 1'b0;

    initial begin : responder
        int req_age, cur_lat;
        logic [DW-1:0] r_data;
        req_age = 0; cur_lat = 0; r_data = '0;
        m_ack = 1'b0; m_rdata = '0;
        forever begin
            step();
            if (m_req) begin
                if (req_age == 0) begin
                    cur_lat = fixed_lat;
                    r_data  = ack_data;
                    if (rand_mode) begin
                        case ($urandom % 25)
                            0:       cur_lat = NEVER;
                            1:       cur_lat = TIMEOUT - 1;
                            2:       cur_lat = TIMEOUT - 2;
                            default: cur_lat = int'($urandom % 4);
                        endcase
                        r_data = $urandom;
                    end
                end
                req_age++;
                m_ack = (req_age == cur_lat + 1);
            end else begin
                req_age = 0;
                m_ack = spur_ack || (rand_mode && ($urandom % 3 == 0));
            end
            m_rdata = m_ack ? (rand_mode ? r_data : ack_data) : $urandom;
        end
    end

    function automatic logic seen(input int sel);
        case (sel)
            0:       return i_gnt;
            1:       return i_done;
            2:       return d_gnt;
            3:       return d_done;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_on(input int sel, input string nm);
        for (int k = 0; k < 200 && !seen(sel); k++) step();
        check(nm, seen(sel), 1'b1);
    endtask

    function automatic int glog_at(input int idx);
        return (idx < glog_own.size()) ? glog_own[idx] : -1;
    endfunction

    function automatic int gcyc_at(input int idx);
        return (idx < glog_cyc.size()) ? glog_cyc[idx] : -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : main
        int t0, base;
        int order[10];
        bit draining;
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_we = 4'h0; d_wdata = '0;
        step(); step();
        chk_en = 1'b1;
        check("reset_busy", busy, 1'b0);
        check("reset_m_req", m_req, 1'b0);
        check("reset_m_addr", m_addr, '0);
        rst = 1'b1;
        step();

        // Fetch only
        fixed_lat = 2; ack_data = 32'h0050_0093;
        i_req = 1'b1; i_addr = 32'h100;
        wait_on(0, "t1_i_gnt"); t0 = cyc;
        check("t1_m_addr", m_addr, 32'h100);
        check("t1_m_we", m_we, 4'h0);
        step();
        check("t1_i_gnt_pulse", i_gnt, 1'b0);
        wait_on(1, "t1_i_done");
        check("t1_latency", cyc - t0, 3);
        check("t1_i_rdata", i_rdata, 32'h0050_0093);
        check("t1_i_err", i_err, 1'b0);
        check("t1_d_done", d_done, 1'b0);
        i_req = 1'b0;
        wait_on(4, "t1_idle");

        // Store then load; fields changed after grant must not leak through
        fixed_lat = 0; ack_data = 32'h1234_5678;
        d_req = 1'b1; d_addr = 32'h2000; d_we = 4'hf; d_wdata = 32'hDEAD_BEEF;
        wait_on(2, "t2_st_gnt");
        check("t2_m_we", m_we, 4'hf);
        check("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check("t2_m_addr", m_addr, 32'h2000);
        d_wdata = '0; d_addr = 32'h5555;
        wait_on(3, "t2_st_done");
        check("t2_st_rdata", d_rdata, '0);
        check("t2_st_err", d_err, 1'b0);
        check("t2_m_we_cleared", m_we, 4'h0);
        check("t2_m_wdata_held", m_wdata, 32'hDEAD_BEEF);
        d_we = 4'h0; d_addr = 32'h2000; ack_data = 32'hDEAD_BEEF;
        wait_on(2, "t2_ld_gnt");
        wait_on(3, "t2_ld_done");
        check("t2_ld_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        wait_on(4, "t2_idle");

        // Contention with immediate ack
        base = glog_own.size();
        fixed_lat = 0; ack_data = 32'h0BAD_F00D;
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h40; d_we = 4'h0;
        for (int k = 0; k < 100 && glog_own.size() < base + 10; k++) step();
        check("t3_grant_count", glog_own.size() - base, 10);
        for (int k = 0; k < 10; k++) check($sformatf("t3_order[%0d]", k), glog_at(base + k), order[k]);
        for (int k = 0; k < 9; k++)
            check($sformatf("t3_spacing[%0d]", k), gcyc_at(base + k + 1) - gcyc_at(base + k), 3);
        wait_on(1, "t3_last_i_done");
        i_req = 1'b0; d_req = 1'b0;
        wait_on(4, "t3_idle");

        // Timeout, then a late ack is ignored
        fixed_lat = NEVER;
        d_req = 1'b1; d_addr = 32'h3000; d_we = 4'h0;
        wait_on(2, "t4_gnt"); t0 = cyc;
        wait_on(3, "t4_done");
        check("t4_latency", cyc - t0, TIMEOUT);
        check("t4_d_err", d_err, 1'b1);
        check("t4_d_rdata", d_rdata, '0);
        check("t4_m_req", m_req, 1'b0);
        d_req = 1'b0; spur_ack = 1'b1; ack_data = 32'hFFFF_0000;
        step(); step(); step();
        spur_ack = 1'b0;
        check("t4_late_ack_done", d_done, 1'b0);
        check("t4_late_ack_busy", busy, 1'b0);
        check("t4_late_ack_rdata", d_rdata, '0);
        wait_on(4, "t4_idle");

        // Ack in the last WAIT cycle beats the timeout
        fixed_lat = TIMEOUT - 1; ack_data = 32'hCAFE_F00D;
        d_req = 1'b1; d_addr = 32'h3004;
        wait_on(2, "t5_gnt"); t0 = cyc;
        wait_on(3, "t5_done");
        check("t5_latency", cyc - t0, TIMEOUT);
        check("t5_d_err", d_err, 1'b0);
        check("t5_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        wait_on(4, "t5_idle");

        // Reset mid-WAIT (data grant with fetch pending bumps the starve count first)
        fixed_lat = NEVER;
        i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h44; d_we = 4'h0;
        wait_on(2, "t6_gnt");
        repeat (5) step();
        fixed_lat = 0; ack_data = 32'h0000_0013;
        rst = 1'b0;
        step();
        rst = 1'b1;
        base = glog_own.size();
        check("t6_busy", busy, 1'b0);
        check("t6_m_req", m_req, 1'b0);
        check("t6_d_done", d_done, 1'b0);
        check("t6_d_err", d_err, 1'b0);
        step();
        check("t6_no_done", d_done, 1'b0);
        for (int k = 0; k < 100 && glog_own.size() < base + 5; k++) step();
        for (int k = 0; k < 5; k++) check($sformatf("t6_order[%0d]", k), glog_at(base + k), order[k]);
        wait_on(1, "t6_i_done");
        check("t6_i_err", i_err, 1'b0);
        check("t6_i_rdata", i_rdata, 32'h0000_0013);
        i_req = 1'b0; d_req = 1'b0;
        wait_on(4, "t6_idle");

        // Randomized traffic against the model
        rand_mode = 1'b1;
        draining = 1'b0;
        for (int n = 0; n < 4300; n++) begin
            step();
            if (n >= 4000) draining = 1'b1;
            if (i_req) begin
                if (i_done) begin
                    i_req = !draining && ($urandom % 2 == 0);
                    i_addr = $urandom;
                end
            end else if (!draining && $urandom % 3 == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_req) begin
                if (d_gnt && $urandom % 2 == 0) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = 4'($urandom);
                end
                if (d_done) begin
                    d_req = !draining && ($urandom % 2 == 0);
                    d_addr = $urandom; d_wdata = $urandom;
                    d_we = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
                end
            end else if (!draining && $urandom % 3 == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_we = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
            end
        end
        rand_mode = 1'b0;
        wait_on(4, "rand_idle");
        check("rand_drained", i_req || d_req, 1'b0);
        check("rand_enough_accesses", n_access > 100, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
